// File: rtl/serial_mag_comp_ctrl_comp1.sv
// rtl/serial_mag_comp_ctrl_comp1.sv - 1-bit magnitude comparator cell
// Zx flags X>Y, Zy flags X<Y, Zeq flags X==Y for one bit pair.
module comp1 (
    input  logic x_i,
    input  logic y_i,
    output logic zx_o,
    output logic zy_o,
    output logic zeq_o
);
    assign zx_o  = x_i & ~y_i;
    assign zy_o  = ~x_i & y_i;
    assign zeq_o = ~(x_i ^ y_i);
endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// rtl/serial_mag_comp_ctrl.sv - bit-serial MSB-first unsigned magnitude compare sequencer
// One comparator cell examines one bit pair per clock; result held until the next accepted START.
module serial_mag_comp_ctrl #(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [W-1:0]             A,
    input  logic [W-1:0]             B,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     GT,
    output logic                     LT,
    output logic                     EQ,
    output logic [$clog2(W+1)-1:0]   NBITS
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int NW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sa_q, sb_q;
    logic [CW-1:0] cnt_q;
    logic          found_q, gtf_q, ltf_q;
    logic          busy_q, done_q, gt_q, lt_q, eq_q;
    logic          busy_d, done_d, gt_d, lt_d, eq_d;
    logic [NW-1:0] nbits_q, nbits_d;

    logic zx, zy, zeq;
    logic start_ok, diff_now, gt_now, lt_now, finish;

    comp1 u_comp1 (
        .x_i   (sa_q[W-1]),
        .y_i   (sb_q[W-1]),
        .zx_o  (zx),
        .zy_o  (zy),
        .zeq_o (zeq)
    );

    // The first differing bit decides; later bits only matter for fixed latency.
    assign start_ok = START && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign diff_now = found_q | ~zeq;
    assign gt_now   = found_q ? gtf_q : zx;
    assign lt_now   = found_q ? ltf_q : zy;
    assign finish   = (state_q == S_RUN) &&
                      ((EARLY_EXIT && diff_now) || (cnt_q == '0));

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start_ok ? S_RUN : S_IDLE;
            S_RUN:   state_d = finish ? S_FIN : S_RUN;
            S_FIN:   state_d = start_ok ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_FIN);
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        nbits_d = nbits_q;
        if (start_ok) begin
            gt_d    = 1'b0;
            lt_d    = 1'b0;
            eq_d    = 1'b0;
            nbits_d = '0;
        end else if (finish) begin
            gt_d    = gt_now;
            lt_d    = lt_now;
            eq_d    = ~diff_now;
            nbits_d = NW'(W) - NW'(cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            gtf_q   <= 1'b0;
            ltf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            nbits_q <= nbits_d;
            if (start_ok) begin
                sa_q    <= A;
                sb_q    <= B;
                cnt_q   <= CW'(W - 1);
                found_q <= 1'b0;
                gtf_q   <= 1'b0;
                ltf_q   <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (!found_q) begin
                    gtf_q   <= zx;
                    ltf_q   <= zy;
                    found_q <= ~zeq;
                end
                if (!finish) begin
                    sa_q  <= sa_q << 1;
                    sb_q  <= sb_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign GT    = gt_q;
    assign LT    = lt_q;
    assign EQ    = eq_q;
    assign NBITS = nbits_q;
endmodule
